dmem_arbiter: RTL and testbench

- Shares the single-port data memory (synchronous, 1-cycle read latency) between two requesters: the core execute path (port c_) and an external host/debug port (port h_).
- Each cycle it arbitrates and muxes the winner onto the memory pins.
- It tags the access so that read data returns to the correct owner one cycle later.
- It supports fixed-priority or round-robin policy, plus a host lock for back-to-back burst access.

---
 rtl/dmem_arbiter.sv | 142 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-port arbiter (core / host) in front of a single-port synchronous data memory.
// Optional starvation guard for the host port is enabled with `define DMEM_ARB_STARVE_EN.
module dmem_arbiter #(
  parameter int AW           = 4,
  parameter int DW           = 8,
  parameter int RR_MODE      = 0,
  parameter int STARVE_LIMIT = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic          c_gnt,
  output logic          c_rvalid,
  output logic [DW-1:0] c_rdata,
  input  logic          h_req,
  input  logic          h_we,
  input  logic          h_lock,
  input  logic [AW-1:0] h_addr,
  input  logic [DW-1:0] h_wdata,
  output logic          h_gnt,
  output logic          h_rvalid,
  output logic [DW-1:0] h_rdata,
  output logic          m_e,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_di,
  input  logic [DW-1:0] m_do
);

  typedef enum logic [1:0] {OWN_IDLE, OWN_CORE, OWN_HOST} owner_e;

  owner_e        owner_q, owner_d;
  logic          rd_pend_q, rd_pend_d;
  logic          rr_last_q, rr_last_d;
  logic          locked_q, locked_d;
  logic [DW-1:0] c_rdata_q, c_rdata_d;
  logic [DW-1:0] h_rdata_q, h_rdata_d;
  logic          force_h;

`ifdef DMEM_ARB_STARVE_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  logic [SW-1:0] starve_q, starve_d;

  assign force_h = (starve_q == SW'(STARVE_LIMIT));

  // Counts consecutive host-wait cycles, saturating at the limit.
  always_comb begin
    starve_d = starve_q;
    if (!h_req || h_gnt)
      starve_d = '0;
    else if (starve_q != SW'(STARVE_LIMIT))
      starve_d = starve_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) starve_q <= '0;
    else     starve_q <= starve_d;
  end
`else
  assign force_h = 1'b0;
`endif

  // Grants are suppressed while reset is asserted.
  always_comb begin
    c_gnt = 1'b0;
    h_gnt = 1'b0;
    if (!rst) begin
      if (locked_q && h_req)
        h_gnt = 1'b1;
      else if (force_h && h_req)
        h_gnt = 1'b1;
      else if (RR_MODE == 0) begin
        if (c_req)      c_gnt = 1'b1;
        else if (h_req) h_gnt = 1'b1;
      end else if (c_req && h_req) begin
        if (rr_last_q) c_gnt = 1'b1;
        else           h_gnt = 1'b1;
      end else if (c_req)
        c_gnt = 1'b1;
      else if (h_req)
        h_gnt = 1'b1;
    end
  end

  always_comb begin
    m_e    = c_gnt | h_gnt;
    m_we   = 1'b0;
    m_addr = '0;
    m_di   = '0;
    if (c_gnt) begin
      m_we   = c_we;
      m_addr = c_addr;
      m_di   = c_wdata;
    end else if (h_gnt) begin
      m_we   = h_we;
      m_addr = h_addr;
      m_di   = h_wdata;
    end
  end

  always_comb begin
    owner_d   = OWN_IDLE;
    rd_pend_d = 1'b0;
    rr_last_d = rr_last_q;
    locked_d  = h_gnt & h_lock;
    if (m_e) begin
      owner_d   = h_gnt ? OWN_HOST : OWN_CORE;
      rd_pend_d = ~m_we;
      rr_last_d = h_gnt;
    end
  end

  // Read data is steered to the owner of the previous access; the other port holds.
  assign c_rvalid = rd_pend_q && (owner_q == OWN_CORE);
  assign h_rvalid = rd_pend_q && (owner_q == OWN_HOST);
  assign c_rdata  = c_rvalid ? m_do : c_rdata_q;
  assign h_rdata  = h_rvalid ? m_do : h_rdata_q;
  assign c_rdata_d = c_rdata;
  assign h_rdata_d = h_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q   <= OWN_IDLE;
      rd_pend_q <= 1'b0;
      rr_last_q <= 1'b1;
      locked_q  <= 1'b0;
      c_rdata_q <= '0;
      h_rdata_q <= '0;
    end else begin
      owner_q   <= owner_d;
      rd_pend_q <= rd_pend_d;
      rr_last_q <= rr_last_d;
      locked_q  <= locked_d;
      c_rdata_q <= c_rdata_d;
      h_rdata_q <= h_rdata_d;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: u0 fixed priority, u1 round-robin, each with its own memory model.
module tb_dmem_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       c_req = 1'b0, c_we = 1'b0;
  logic [3:0] c_addr = '0;
  logic [7:0] c_wdata = '0;
  logic       h_req = 1'b0, h_we = 1'b0, h_lock = 1'b0;
  logic [3:0] h_addr = '0;
  logic [7:0] h_wdata = '0;

  logic       c_gnt0, c_rvalid0, h_gnt0, h_rvalid0, m_e0, m_we0;
  logic [7:0] c_rdata0, h_rdata0, m_di0, m_do0;
  logic [3:0] m_addr0;
  logic       c_gnt1, c_rvalid1, h_gnt1, h_rvalid1, m_e1, m_we1;
  logic [7:0] c_rdata1, h_rdata1, m_di1, m_do1;
  logic [3:0] m_addr1;

  logic [7:0] mem0 [16];
  logic [7:0] mem1 [16];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.AW(4), .DW(8), .RR_MODE(0), .STARVE_LIMIT(8)) u0 (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt0), .c_rvalid(c_rvalid0), .c_rdata(c_rdata0),
    .h_req(h_req), .h_we(h_we), .h_lock(h_lock), .h_addr(h_addr), .h_wdata(h_wdata),
    .h_gnt(h_gnt0), .h_rvalid(h_rvalid0), .h_rdata(h_rdata0),
    .m_e(m_e0), .m_we(m_we0), .m_addr(m_addr0), .m_di(m_di0), .m_do(m_do0)
  );

  dmem_arbiter #(.AW(4), .DW(8), .RR_MODE(1), .STARVE_LIMIT(8)) u1 (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt1), .c_rvalid(c_rvalid1), .c_rdata(c_rdata1),
    .h_req(h_req), .h_we(h_we), .h_lock(h_lock), .h_addr(h_addr), .h_wdata(h_wdata),
    .h_gnt(h_gnt1), .h_rvalid(h_rvalid1), .h_rdata(h_rdata1),
    .m_e(m_e1), .m_we(m_we1), .m_addr(m_addr1), .m_di(m_di1), .m_do(m_do1)
  );

  always @(posedge clk) begin
    if (m_e0) begin
      if (m_we0) mem0[m_addr0] <= m_di0;
      else       m_do0 <= mem0[m_addr0];
    end
    if (m_e1) begin
      if (m_we1) mem1[m_addr1] <= m_di1;
      else       m_do1 <= mem1[m_addr1];
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    c_req = 0; c_we = 0; c_addr = 0; c_wdata = 0;
    h_req = 0; h_we = 0; h_lock = 0; h_addr = 0; h_wdata = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1;
    step();
    step();
    rst = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    c_req = 1; h_req = 1; h_lock = 1; c_addr = 4'h5; h_addr = 4'h6;
    @(negedge clk);
    total++; if (c_gnt0 !== 1'b0 || h_gnt0 !== 1'b0) begin bad++; $display("FAIL reset_gnt: got c=%b h=%b want 0 0", c_gnt0, h_gnt0); end
    total++; if (m_e0 !== 1'b0 || m_we0 !== 1'b0 || m_addr0 !== 4'h0 || m_di0 !== 8'h00) begin bad++; $display("FAIL reset_mem_pins: got e=%b we=%b a=%h d=%h want 0", m_e0, m_we0, m_addr0, m_di0); end
    total++; if (c_rvalid0 !== 1'b0 || h_rvalid0 !== 1'b0 || c_rdata0 !== 8'h00 || h_rdata0 !== 8'h00) begin bad++; $display("FAIL reset_rd: got cv=%b hv=%b cd=%h hd=%h want 0", c_rvalid0, h_rvalid0, c_rdata0, h_rdata0); end
    total++; if (c_gnt1 !== 1'b0 || h_gnt1 !== 1'b0 || m_e1 !== 1'b0) begin bad++; $display("FAIL reset_rr_gnt: got c=%b h=%b e=%b want 0", c_gnt1, h_gnt1, m_e1); end
    step();
    do_reset();
  endtask

  task automatic test_core_read();
    do_reset();
    c_req = 1; c_we = 1; c_addr = 4'h3; c_wdata = 8'hA5;
    @(negedge clk);
    total++; if (c_gnt0 !== 1'b1 || m_we0 !== 1'b1 || m_di0 !== 8'hA5) begin bad++; $display("FAIL core_write: got gnt=%b we=%b di=%h want 1 1 a5", c_gnt0, m_we0, m_di0); end
    step();
    c_we = 0;
    @(negedge clk);
    total++; if (c_gnt0 !== 1'b1 || m_addr0 !== 4'h3 || m_we0 !== 1'b0 || m_e0 !== 1'b1) begin bad++; $display("FAIL core_read_gnt: got gnt=%b a=%h we=%b e=%b want 1 3 0 1", c_gnt0, m_addr0, m_we0, m_e0); end
    total++; if (c_rvalid0 !== 1'b0) begin bad++; $display("FAIL write_no_rvalid: got %b want 0", c_rvalid0); end
    step();
    c_req = 0;
    @(negedge clk);
    total++; if (c_rvalid0 !== 1'b1 || c_rdata0 !== 8'hA5) begin bad++; $display("FAIL core_read_data: got v=%b d=%h want 1 a5", c_rvalid0, c_rdata0); end
    total++; if (h_rvalid0 !== 1'b0 || m_e0 !== 1'b0 || m_addr0 !== 4'h0) begin bad++; $display("FAIL core_read_other: got hv=%b e=%b a=%h want 0 0 0", h_rvalid0, m_e0, m_addr0); end
    step();
    @(negedge clk);
    total++; if (c_rvalid0 !== 1'b0 || c_rdata0 !== 8'hA5) begin bad++; $display("FAIL core_rdata_hold: got v=%b d=%h want 0 a5", c_rvalid0, c_rdata0); end
  endtask

  task automatic test_fixed_prio();
    do_reset();
    c_req = 1; c_we = 1; c_addr = 4'h2; c_wdata = 8'h11;
    h_req = 1; h_we = 0; h_addr = 4'h2;
    @(negedge clk);
    total++; if (c_gnt0 !== 1'b1 || h_gnt0 !== 1'b0) begin bad++; $display("FAIL fixed_cycle0: got c=%b h=%b want 1 0", c_gnt0, h_gnt0); end
    step();
    c_req = 0;
    @(negedge clk);
    total++; if (h_gnt0 !== 1'b1 || c_gnt0 !== 1'b0 || m_addr0 !== 4'h2 || m_we0 !== 1'b0) begin bad++; $display("FAIL fixed_cycle1: got h=%b c=%b a=%h we=%b want 1 0 2 0", h_gnt0, c_gnt0, m_addr0, m_we0); end
    step();
    h_req = 0;
    @(negedge clk);
    total++; if (h_rvalid0 !== 1'b1 || h_rdata0 !== 8'h11 || c_rvalid0 !== 1'b0) begin bad++; $display("FAIL fixed_return: got hv=%b hd=%h cv=%b want 1 11 0", h_rvalid0, h_rdata0, c_rvalid0); end
    step();
  endtask

  task automatic test_round_robin();
    do_reset();
    c_req = 1; c_we = 1;
    c_addr = 4'h4; c_wdata = 8'h44; step();
    c_addr = 4'h5; c_wdata = 8'h55; step();
    clear_inputs();
    h_req = 1; h_we = 1;
    h_addr = 4'h6; h_wdata = 8'h66; step();
    h_addr = 4'h7; h_wdata = 8'h77; step();
    do_reset();
    c_req = 1; c_we = 0; c_addr = 4'h4;
    h_req = 1; h_we = 0; h_addr = 4'h6;
    @(negedge clk);
    total++; if (c_gnt1 !== 1'b1 || h_gnt1 !== 1'b0) begin bad++; $display("FAIL rr_grant0: got c=%b h=%b want 1 0", c_gnt1, h_gnt1); end
    step();
    c_addr = 4'h5;
    @(negedge clk);
    total++; if (h_gnt1 !== 1'b1 || c_gnt1 !== 1'b0) begin bad++; $display("FAIL rr_grant1: got c=%b h=%b want 0 1", c_gnt1, h_gnt1); end
    total++; if (c_rvalid1 !== 1'b1 || c_rdata1 !== 8'h44 || h_rvalid1 !== 1'b0) begin bad++; $display("FAIL rr_ret1: got cv=%b cd=%h hv=%b want 1 44 0", c_rvalid1, c_rdata1, h_rvalid1); end
    step();
    h_addr = 4'h7;
    @(negedge clk);
    total++; if (c_gnt1 !== 1'b1 || h_gnt1 !== 1'b0 || m_addr1 !== 4'h5) begin bad++; $display("FAIL rr_grant2: got c=%b h=%b a=%h want 1 0 5", c_gnt1, h_gnt1, m_addr1); end
    total++; if (h_rvalid1 !== 1'b1 || h_rdata1 !== 8'h66 || c_rvalid1 !== 1'b0) begin bad++; $display("FAIL rr_ret2: got hv=%b hd=%h cv=%b want 1 66 0", h_rvalid1, h_rdata1, c_rvalid1); end
    step();
    c_req = 0;
    @(negedge clk);
    total++; if (h_gnt1 !== 1'b1 || c_gnt1 !== 1'b0 || m_addr1 !== 4'h7) begin bad++; $display("FAIL rr_grant3: got c=%b h=%b a=%h want 0 1 7", c_gnt1, h_gnt1, m_addr1); end
    total++; if (c_rvalid1 !== 1'b1 || c_rdata1 !== 8'h55) begin bad++; $display("FAIL rr_ret3: got cv=%b cd=%h want 1 55", c_rvalid1, c_rdata1); end
    step();
    h_req = 0;
    @(negedge clk);
    total++; if (h_rvalid1 !== 1'b1 || h_rdata1 !== 8'h77 || c_rdata1 !== 8'h55) begin bad++; $display("FAIL rr_ret4: got hv=%b hd=%h cd=%h want 1 77 55", h_rvalid1, h_rdata1, c_rdata1); end
    step();
  endtask

  task automatic test_lock();
    do_reset();
    h_req = 1; h_we = 1; c_we = 0; c_addr = 4'h3;
    for (int i = 0; i < 4; i++) begin
      h_addr  = 4'(i);
      h_wdata = 8'(8'h20 + i);
      h_lock  = (i < 3);
      c_req   = (i > 0);
      @(negedge clk);
      total++; if (h_gnt0 !== 1'b1 || c_gnt0 !== 1'b0 || m_addr0 !== 4'(i)) begin bad++; $display("FAIL lock_burst%0d: got h=%b c=%b a=%h want 1 0 %0d", i, h_gnt0, c_gnt0, m_addr0, i); end
      step();
    end
    h_req = 0; h_lock = 0;
    @(negedge clk);
    total++; if (c_gnt0 !== 1'b1 || h_gnt0 !== 1'b0) begin bad++; $display("FAIL lock_release: got c=%b h=%b want 1 0", c_gnt0, h_gnt0); end
    step();
    c_req = 0;
    step();
    total++; if (mem0[2] !== 8'h22) begin bad++; $display("FAIL lock_write_data: got %h want 22", mem0[2]); end
  endtask

  task automatic test_starve();
    do_reset();
    c_req = 1; c_we = 0; c_addr = 4'h0;
    h_req = 1; h_we = 0; h_addr = 4'h1;
`ifdef DMEM_ARB_STARVE_EN
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      if (i < 9) begin
        total++; if (h_gnt0 !== 1'b0 || c_gnt0 !== 1'b1) begin bad++; $display("FAIL starve_wait%0d: got h=%b c=%b want 0 1", i, h_gnt0, c_gnt0); end
      end else begin
        total++; if (h_gnt0 !== 1'b1 || c_gnt0 !== 1'b0) begin bad++; $display("FAIL starve_force: got h=%b c=%b want 1 0", h_gnt0, c_gnt0); end
      end
      step();
    end
    h_req = 0;
    @(negedge clk);
    total++; if (c_gnt0 !== 1'b1) begin bad++; $display("FAIL starve_after: got c=%b want 1", c_gnt0); end
`else
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      total++; if (h_gnt0 !== 1'b0 || c_gnt0 !== 1'b1) begin bad++; $display("FAIL starve_none%0d: got h=%b c=%b want 0 1", i, h_gnt0, c_gnt0); end
      step();
    end
`endif
    clear_inputs();
    step();
  endtask

  task automatic test_async_reset();
    do_reset();
    c_req = 1; c_we = 0; c_addr = 4'h3;
    @(negedge clk);
    total++; if (c_gnt0 !== 1'b1) begin bad++; $display("FAIL areset_pre: got %b want 1", c_gnt0); end
    #1 rst = 1;
    #1;
    total++; if (c_gnt0 !== 1'b0 || m_e0 !== 1'b0 || m_addr0 !== 4'h0 || c_rvalid0 !== 1'b0 || c_rdata0 !== 8'h00) begin bad++; $display("FAIL areset_now: got g=%b e=%b a=%h v=%b d=%h want 0", c_gnt0, m_e0, m_addr0, c_rvalid0, c_rdata0); end
    step();
    total++; if (c_rvalid0 !== 1'b0 || h_rvalid0 !== 1'b0 || c_gnt0 !== 1'b0) begin bad++; $display("FAIL areset_discard: got cv=%b hv=%b g=%b want 0", c_rvalid0, h_rvalid0, c_gnt0); end
    h_req = 1; h_we = 0; h_addr = 4'h1;
    rst = 0;
    @(negedge clk);
    total++; if (c_gnt0 !== 1'b1 || c_gnt1 !== 1'b1 || h_gnt1 !== 1'b0) begin bad++; $display("FAIL areset_first: got c0=%b c1=%b h1=%b want 1 1 0", c_gnt0, c_gnt1, h_gnt1); end
    step();
    clear_inputs();
    step();
  endtask

  initial begin
    test_reset();
    test_core_read();
    test_fixed_prio();
    test_round_robin();
    test_lock();
    test_starve();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
